// File: rtl/sprite_pixel_pipe.sv
// Multi-sprite pixel renderer: hit-test, sprite ROM fetch, palette lookup; 3-cycle latency.
// Define SPRITE_MIRROR_EN to add the per-sprite horizontal mirror input SprFlip.
module sprite_pixel_pipe #(
  parameter int unsigned SPR_W  = 16,
  parameter int unsigned SPR_H  = 16,
  parameter int unsigned BPP    = 4,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned N_SPR  = 4,
  parameter int unsigned FRAMES = 8,
  parameter int unsigned ADDR_W = 8,
  localparam int unsigned FRM_W = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int unsigned ID_W  = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    pix_valid,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic [N_SPR*10-1:0]     SprX,
  input  logic [N_SPR*10-1:0]     SprY,
  input  logic [N_SPR*FRM_W-1:0]  SprFrame,
  input  logic [N_SPR-1:0]        SprEn,
`ifdef SPRITE_MIRROR_EN
  input  logic [N_SPR-1:0]        SprFlip,
`endif
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [WORD_W-1:0]       rom_data,
  input  logic                    pal_we,
  input  logic [BPP-1:0]          pal_addr,
  input  logic [11:0]             pal_data,
  output logic [3:0]              Red,
  output logic [3:0]              Green,
  output logic [3:0]              Blue,
  output logic                    spr_hit,
  output logic [ID_W-1:0]         spr_id,
  output logic                    out_valid
);

  localparam int unsigned PPW     = WORD_W / BPP;
  localparam int unsigned PW      = $clog2(PPW);
  localparam int unsigned FIELD_W = (PW > 0) ? PW : 1;
  localparam int unsigned LX      = $clog2(SPR_W);
  localparam int unsigned LY      = $clog2(SPR_H);
  localparam int unsigned LIN_W   = LX + LY;
  localparam int unsigned WPF     = SPR_W * SPR_H / PPW;
  localparam int unsigned N_PAL   = 1 << BPP;

  typedef struct packed {
    logic               valid;
    logic               hit;
    logic [ID_W-1:0]    id;
    logic [FIELD_W-1:0] field;
  } stage_t;

  stage_t s1, s2;

  logic               hit_c;
  logic [ID_W-1:0]    id_c;
  logic [LX-1:0]      dx_c;
  logic [LY-1:0]      dy_c;
  logic [FRM_W-1:0]   frame_c;
  logic [10:0]        sx_c;
  logic [10:0]        sy_c;
  logic [LIN_W-1:0]   lin_c;
  logic [FIELD_W-1:0] field_c;
  logic [ADDR_W-1:0]  addr_c;
`ifdef SPRITE_MIRROR_EN
  logic               flip_c;
`endif

  logic [11:0]        palette [N_PAL];
  logic [BPP-1:0]     idx_c;

  // Hit test; scanning from the top index down lets the lowest hitting sprite win.
  always_comb begin
    hit_c   = 1'b0;
    id_c    = '0;
    dx_c    = '0;
    dy_c    = '0;
    frame_c = '0;
    sx_c    = '0;
    sy_c    = '0;
`ifdef SPRITE_MIRROR_EN
    flip_c  = 1'b0;
`endif
    for (int i = N_SPR - 1; i >= 0; i--) begin
      sx_c = {1'b0, SprX[10*i +: 10]};
      sy_c = {1'b0, SprY[10*i +: 10]};
      if (SprEn[i] &&
          ({1'b0, DrawX} >= sx_c) && ({1'b0, DrawX} < sx_c + 11'(SPR_W)) &&
          ({1'b0, DrawY} >= sy_c) && ({1'b0, DrawY} < sy_c + 11'(SPR_H))) begin
        hit_c   = 1'b1;
        id_c    = ID_W'(i);
        dx_c    = LX'(DrawX - SprX[10*i +: 10]);
        dy_c    = LY'(DrawY - SprY[10*i +: 10]);
        frame_c = SprFrame[FRM_W*i +: FRM_W];
`ifdef SPRITE_MIRROR_EN
        flip_c  = SprFlip[i];
`endif
      end
    end
`ifdef SPRITE_MIRROR_EN
    if (flip_c) dx_c = LX'(SPR_W - 1) - dx_c;
`endif
    // Power-of-2 sprite width makes dy*SPR_W+dx a plain concatenation.
    lin_c   = {dy_c, dx_c};
    field_c = FIELD_W'(lin_c % LIN_W'(PPW));
    addr_c  = ADDR_W'(frame_c) * ADDR_W'(WPF) + ADDR_W'(lin_c / LIN_W'(PPW));
  end

  // Stage 1: capture hit result and issue the ROM address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1       <= '0;
      rom_addr <= '0;
    end else begin
      s1.valid <= pix_valid;
      s1.hit   <= pix_valid && hit_c;
      s1.id    <= id_c;
      s1.field <= field_c;
      if (pix_valid && hit_c) rom_addr <= addr_c;
    end
  end

  // Stage 2: align pixel context with the ROM read latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) s2 <= '0;
    else          s2 <= s1;
  end

  // Run-time palette; a same-edge lookup sees the pre-write entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned k = 0; k < N_PAL; k++) palette[k] <= '0;
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

  assign idx_c = rom_data[32'(s2.field) * BPP +: BPP];

  // Stage 3: palette lookup; index 0 is transparent with no fall-through.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      spr_hit   <= 1'b0;
      spr_id    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s2.valid;
      if (s2.valid && s2.hit && (idx_c != '0)) begin
        {Red, Green, Blue} <= palette[idx_c];
        spr_hit            <= 1'b1;
        spr_id             <= s2.id;
      end else begin
        {Red, Green, Blue} <= '0;
        spr_hit            <= 1'b0;
        spr_id             <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Bench for sprite_pixel_pipe: directed vector table, corner sequences and a modelled streaming line.
module tb_sprite_pixel_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic [9:0]  draw_x, draw_y;
  logic [39:0] spr_x, spr_y;
  logic [11:0] spr_frame;
  logic [3:0]  spr_en;
`ifdef SPRITE_MIRROR_EN
  logic [3:0]  spr_flip;
`endif
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic [3:0]  red, green, blue;
  logic        spr_hit;
  logic [1:0]  spr_id;
  logic        out_valid;

  logic [31:0] rom   [256];
  logic [11:0] pal_m [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  sprite_pixel_pipe dut (
    .Clk(clk), .Reset_n(rst_n), .pix_valid(pix_valid), .DrawX(draw_x), .DrawY(draw_y),
    .SprX(spr_x), .SprY(spr_y), .SprFrame(spr_frame), .SprEn(spr_en),
`ifdef SPRITE_MIRROR_EN
    .SprFlip(spr_flip),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .Red(red), .Green(green), .Blue(blue), .spr_hit(spr_hit),
    .spr_id(spr_id), .out_valid(out_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_spr(input int i, input logic [9:0] x, input logic [9:0] y, input logic [2:0] fr);
    spr_x[10*i +: 10]   = x;
    spr_y[10*i +: 10]   = y;
    spr_frame[3*i +: 3] = fr;
  endtask

  task automatic pal_write(input logic [3:0] k, input logic [11:0] v);
    @(negedge clk);
    pal_we = 1'b1; pal_addr = k; pal_data = v;
    @(negedge clk);
    pal_we = 1'b0;
    pal_m[k] = v;
  endtask

  // One isolated pixel: address checked after edge 1, colour after edge 3, bubble after that.
  task automatic run_pixel(input string name, input logic [9:0] x, input logic [9:0] y,
                           input logic [7:0] e_addr, input logic e_hit, input logic [1:0] e_id,
                           input logic [11:0] e_rgb);
    @(negedge clk);
    draw_x = x; draw_y = y; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    check({name, "_addr"}, 32'(rom_addr), 32'(e_addr));
    @(negedge clk);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_hit_rgb"}, {19'd0, spr_hit, red, green, blue}, {19'd0, e_hit, e_rgb});
    if (e_hit) check({name, "_id"}, 32'(spr_id), 32'(e_id));
    @(negedge clk);
    check({name, "_bubble"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [9:0]  x, y, sx0, sy0;
    logic [2:0]  fr0;
    logic [3:0]  en;
    logic [7:0]  addr;
    logic        hit;
    logic [1:0]  id;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl [15];

  // Stream model: first enabled sprite covering the pixel decides; its index 0 means transparent.
  int sxm [4], sym [4], frm [4];
  function automatic logic [14:0] model(input int x, input int y);
    for (int i = 0; i < 4; i++) begin
      if (x >= sxm[i] && x < sxm[i] + 16 && y >= sym[i] && y < sym[i] + 16) begin
        int lin;
        logic [31:0] w;
        logic [3:0] idx;
        lin = (y - sym[i]) * 16 + (x - sxm[i]);
        w   = rom[frm[i] * 32 + lin / 8];
        idx = 4'((w >> (4 * (lin % 8))) & 32'hF);
        if (idx == 4'd0) return 15'd0;
        return {1'b1, 2'(i), pal_m[idx]};
      end
    end
    return 15'd0;
  endfunction

  logic hv [4096];
  int   hx [4096];

  initial begin
    logic [14:0] m;
    int px, last_c, pend_k;
    logic pend, wrote, v;
    logic [11:0] pend_v;

    rst_n = 1'b0; pix_valid = 1'b0; draw_x = '0; draw_y = '0;
    spr_x = '0; spr_y = '0; spr_frame = '0; spr_en = '0;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0;
`ifdef SPRITE_MIRROR_EN
    spr_flip = '0;
`endif
    for (int w = 0; w < 256; w++) begin
      if (w < 32 || (w >= 64 && w < 96)) rom[w] = 32'h8765_4321;
      else if (w < 64)                   rom[w] = 32'h0;
      else                               rom[w] = $urandom;
    end

    repeat (2) @(negedge clk);
    check("reset_state", {16'd0, out_valid, spr_hit, spr_id, red, green, blue, rom_addr}, 32'd0);
    rst_n = 1'b1;

    pal_m[0] = 12'h000;
    pal_write(4'd1, 12'hF00);
    for (int k = 2; k < 16; k++) pal_write(4'(k), {4'(k), 4'(k), 4'(k)});

    set_spr(1, 10'd98, 10'd50, 3'd0);
    set_spr(2, 10'd200, 10'd100, 3'd0);
    set_spr(3, 10'd200, 10'd100, 3'd0);

    //            x     y    sx0   sy0  fr0  en       addr  hit id  rgb
    tbl[0]  = '{10'd100,  10'd50,  10'd100,  10'd50, 3'd0, 4'b0001, 8'd0,  1'b1, 2'd0, 12'hF00};
    tbl[1]  = '{10'd103,  10'd51,  10'd100,  10'd50, 3'd0, 4'b0001, 8'd2,  1'b1, 2'd0, 12'h444};
    tbl[2]  = '{10'd103,  10'd51,  10'd100,  10'd50, 3'd2, 4'b0001, 8'd66, 1'b1, 2'd0, 12'h444};
    tbl[3]  = '{10'd101,  10'd50,  10'd100,  10'd50, 3'd0, 4'b0011, 8'd0,  1'b1, 2'd0, 12'h222};
    tbl[4]  = '{10'd101,  10'd50,  10'd100,  10'd50, 3'd1, 4'b0011, 8'd32, 1'b0, 2'd0, 12'h000};
    tbl[5]  = '{10'd101,  10'd50,  10'd100,  10'd50, 3'd1, 4'b0010, 8'd0,  1'b1, 2'd1, 12'h444};
    tbl[6]  = '{10'd1023, 10'd50,  10'd1015, 10'd50, 3'd0, 4'b0001, 8'd1,  1'b1, 2'd0, 12'hF00};
    tbl[7]  = '{10'd0,    10'd50,  10'd1015, 10'd50, 3'd0, 4'b0001, 8'd1,  1'b0, 2'd0, 12'h000};
    tbl[8]  = '{10'd116,  10'd50,  10'd100,  10'd50, 3'd0, 4'b0001, 8'd1,  1'b0, 2'd0, 12'h000};
    tbl[9]  = '{10'd100,  10'd50,  10'd100,  10'd50, 3'd0, 4'b0000, 8'd1,  1'b0, 2'd0, 12'h000};
    tbl[10] = '{10'd115,  10'd65,  10'd100,  10'd50, 3'd0, 4'b0001, 8'd31, 1'b1, 2'd0, 12'h888};
    tbl[11] = '{10'd100,  10'd49,  10'd100,  10'd50, 3'd0, 4'b0001, 8'd31, 1'b0, 2'd0, 12'h000};
    tbl[12] = '{10'd205,  10'd100, 10'd100,  10'd50, 3'd0, 4'b0100, 8'd0,  1'b1, 2'd2, 12'h666};
    tbl[13] = '{10'd215,  10'd115, 10'd100,  10'd50, 3'd0, 4'b1100, 8'd31, 1'b1, 2'd2, 12'h888};
    tbl[14] = '{10'd216,  10'd100, 10'd100,  10'd50, 3'd0, 4'b1100, 8'd31, 1'b0, 2'd0, 12'h000};

    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      set_spr(0, tbl[r].sx0, tbl[r].sy0, tbl[r].fr0);
      spr_en = tbl[r].en;
      run_pixel($sformatf("row%0d", r), tbl[r].x, tbl[r].y, tbl[r].addr,
                tbl[r].hit, tbl[r].id, tbl[r].rgb);
    end

`ifdef SPRITE_MIRROR_EN
    set_spr(0, 10'd100, 10'd50, 3'd0);
    spr_en = 4'b0001; spr_flip = 4'b0001;
    run_pixel("mirror", 10'd100, 10'd50, 8'd1, 1'b1, 2'd0, 12'h888);
    spr_flip = 4'b0000;
`endif

    // Sprite inputs changed after edge 1 must not affect the in-flight pixel.
    set_spr(0, 10'd100, 10'd50, 3'd0);
    spr_en = 4'b0001;
    @(negedge clk);
    draw_x = 10'd100; draw_y = 10'd50; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0; spr_en = 4'b0000; set_spr(0, 10'd500, 10'd500, 3'd1);
    @(negedge clk);
    @(negedge clk);
    check("inflight_hit_rgb", {19'd0, spr_hit, red, green, blue}, {19'd0, 1'b1, 12'hF00});
    set_spr(0, 10'd100, 10'd50, 3'd0);
    spr_en = 4'b0001;

    // Palette write on the lookup edge: old value out now, new value next time.
    @(negedge clk);
    draw_x = 10'd101; draw_y = 10'd50; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    pal_we = 1'b1; pal_addr = 4'd2; pal_data = 12'hABC;
    @(negedge clk);
    pal_we = 1'b0; pal_m[2] = 12'hABC;
    check("pal_same_edge_old", {20'd0, red, green, blue}, 32'h222);
    run_pixel("pal_new", 10'd101, 10'd50, 8'd0, 1'b1, 2'd0, 12'hABC);
    pal_write(4'd2, 12'h222);

    // Reset mid-stream with pixels in flight.
    @(negedge clk);
    draw_x = 10'd100; draw_y = 10'd50; pix_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_hit", 32'(spr_hit), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("reset_immediate", {16'd0, out_valid, spr_hit, spr_id, red, green, blue, rom_addr}, 32'd0);
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_drop%0d", i), 32'(out_valid), 32'd0);
    end
    for (int k = 0; k < 16; k++) pal_m[k] = 12'h000;
    run_pixel("pal_cleared", 10'd100, 10'd50, 8'd0, 1'b1, 2'd0, 12'h000);
    pal_write(4'd1, 12'hF00);
    for (int k = 2; k < 16; k++) pal_write(4'(k), {4'(k), 4'(k), 4'(k)});

    // Streaming line with random bubbles and a mid-line palette write.
    sxm = '{40, 48, 300, 630}; sym = '{55, 52, 60, 50}; frm = '{3, 4, 5, 6};
    for (int i = 0; i < 4; i++) set_spr(i, 10'(sxm[i]), 10'(sym[i]), 3'(frm[i]));
    spr_en = 4'b1111;
    draw_y = 10'd60;
    px = 0; last_c = -1; pend = 1'b0; wrote = 1'b0; pend_k = 0; pend_v = '0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        check("stream_valid", 32'(out_valid), 32'(hv[c-3]));
        m = hv[c-3] ? model(hx[c-3], 60) : 15'd0;
        check($sformatf("stream_px%0d", hx[c-3]), {19'd0, spr_hit, red, green, blue},
              {19'd0, m[14], m[11:0]});
        if (m[14]) check("stream_id", 32'(spr_id), 32'(m[13:12]));
      end
      if (pend) begin
        pal_m[pend_k] = pend_v;
        pend = 1'b0;
      end
      pal_we = 1'b0;
      if (px == 320 && !wrote) begin
        pal_we = 1'b1; pal_addr = 4'd7; pal_data = 12'h5A5;
        pend = 1'b1; pend_k = 7; pend_v = 12'h5A5; wrote = 1'b1;
      end
      v = (px < 640) && ($urandom_range(0, 3) != 0);
      pix_valid = v; draw_x = 10'(px);
      hv[c] = v; hx[c] = px;
      if (v) px++;
      if (px == 640 && last_c < 0) last_c = c;
      if (last_c >= 0 && c == last_c + 3) break;
    end
    pix_valid = 1'b0;
    check("stream_complete", 32'(last_c >= 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
